// File: rtl/icache_refill.sv
// Direct-mapped instruction cache, 64 lines x 16 B, with a 4-beat refill engine.
// A lookup hits combinationally in IDLE; a miss fetches the whole line one 32-bit beat at a time.
module icache_refill (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] FE_PC,
    input  logic        FE_REQ,
    input  logic        FLUSH,
    output logic        ICACHE_R,
    output logic [31:0] ICACHE_INSTR,
    output logic        ICACHE_IAF,
    output logic        MEM_REQ,
    output logic [63:0] MEM_ADDR,
    input  logic        MEM_RDY,
    input  logic [31:0] MEM_DATA,
    input  logic        MEM_ERR
);

    // state  | meaning
    // IDLE   | serve lookups, start a refill on a miss
    // REFILL | fetch beats 0..3 of the latched line
    // FAULT  | report an access fault for one cycle
    typedef enum logic [1:0] {IDLE, REFILL, FAULT} state_t;

    state_t      state, state_nxt;
    logic [63:0] valid;
    logic [53:0] tag_mem  [64];
    logic [31:0] data_mem [256];
    logic [59:0] line_addr;
    logic [1:0]  beat;
    logic        flush_pend;

    logic [5:0]  pc_idx;
    logic [53:0] pc_tag;
    logic [5:0]  refill_idx;
    logic        hit;
    logic        start_miss;
    logic        beat_ok;
    logic        unused_pc_bits;

    assign pc_idx         = FE_PC[9:4];
    assign pc_tag         = FE_PC[63:10];
    assign refill_idx     = line_addr[5:0];
    assign hit            = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign unused_pc_bits = ^FE_PC[1:0];

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ICACHE_R     = 1'b0;
        ICACHE_INSTR = 32'h0;
        ICACHE_IAF   = 1'b0;
        MEM_REQ      = 1'b0;
        MEM_ADDR     = 64'h0;
        start_miss   = 1'b0;
        beat_ok      = 1'b0;
        case (state)
            IDLE: begin
                if (FE_REQ && !FLUSH) begin
                    if (hit) begin
                        ICACHE_R     = 1'b1;
                        ICACHE_INSTR = data_mem[{pc_idx, FE_PC[3:2]}];
                    end else begin
                        start_miss = 1'b1;
                        state_nxt  = REFILL;
                    end
                end
            end
            REFILL: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = {line_addr, beat, 2'b00};
                if (MEM_RDY) begin
                    if (MEM_ERR) begin
                        state_nxt = FAULT;
                    end else begin
                        beat_ok = 1'b1;
                        if (beat == 2'd3) state_nxt = IDLE;
                    end
                end
            end
            FAULT: begin
                state_nxt = IDLE;
                // a flush in the fault cycle swallows the fault report
                if (!FLUSH) begin
                    ICACHE_R   = 1'b1;
                    ICACHE_IAF = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // reset takes effect in the same cycle so an in-flight beat is dropped
        if (RESET) begin
            state_nxt    = IDLE;
            ICACHE_R     = 1'b0;
            ICACHE_INSTR = 32'h0;
            ICACHE_IAF   = 1'b0;
            MEM_REQ      = 1'b0;
            MEM_ADDR     = 64'h0;
            start_miss   = 1'b0;
            beat_ok      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid      <= '0;
            beat       <= 2'd0;
            flush_pend <= 1'b0;
            line_addr  <= '0;
        end else begin
            if (start_miss) begin
                line_addr      <= FE_PC[63:4];
                beat           <= 2'd0;
                flush_pend     <= 1'b0;
                valid[pc_idx]  <= 1'b0;
            end
            if (beat_ok) beat <= beat + 2'd1;
            if (FLUSH) begin
                valid <= '0;
                if (state == REFILL) flush_pend <= 1'b1;
            end
            if (beat_ok && beat == 2'd3 && !flush_pend && !FLUSH)
                valid[refill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (beat_ok) data_mem[{refill_idx, beat}] <= MEM_DATA;
        if (beat_ok && beat == 2'd3) tag_mem[refill_idx] <= line_addr[59:6];
    end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus pushes expected beats/instructions,
// a negedge monitor pops and compares whenever the cache presents a beat or an instruction.
module tb_icache_refill;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] FE_PC;
    logic        FE_REQ;
    logic        FLUSH;
    logic        ICACHE_R;
    logic [31:0] ICACHE_INSTR;
    logic        ICACHE_IAF;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic        MEM_RDY;
    logic [31:0] MEM_DATA;
    logic        MEM_ERR;

    icache_refill dut (
        .CLK(CLK), .RESET(RESET), .FE_PC(FE_PC), .FE_REQ(FE_REQ), .FLUSH(FLUSH),
        .ICACHE_R(ICACHE_R), .ICACHE_INSTR(ICACHE_INSTR), .ICACHE_IAF(ICACHE_IAF),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_RDY(MEM_RDY),
        .MEM_DATA(MEM_DATA), .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_addr;
        logic [63:0] addr;
        logic [31:0] instr;
        logic        iaf;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && MEM_REQ && MEM_RDY) begin
            exp_t e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_addr: unexpected beat at 0x%0h, nothing expected", MEM_ADDR);
            end else begin
                e = sb.pop_front();
                if (!e.is_addr || MEM_ADDR !== e.addr) begin
                    miscompares++;
                    $display("FAIL beat_addr: got 0x%0h, expected 0x%0h (is_addr=%0d)", MEM_ADDR, e.addr, e.is_addr);
                end
            end
        end
        if (!RESET && ICACHE_R) begin
            exp_t e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL instr: unexpected ICACHE_R instr=0x%0h iaf=%0d", ICACHE_INSTR, ICACHE_IAF);
            end else begin
                e = sb.pop_front();
                if (e.is_addr || ICACHE_INSTR !== e.instr || ICACHE_IAF !== e.iaf) begin
                    miscompares++;
                    $display("FAIL instr: got 0x%0h iaf=%0d, expected 0x%0h iaf=%0d",
                             ICACHE_INSTR, ICACHE_IAF, e.instr, e.iaf);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_addr(input logic [63:0] a);
        exp_t e;
        e.is_addr = 1'b1; e.addr = a; e.instr = 32'h0; e.iaf = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_instr(input logic [31:0] i, input logic f);
        exp_t e;
        e.is_addr = 1'b0; e.addr = 64'h0; e.instr = i; e.iaf = f;
        sb.push_back(e);
    endtask

    task automatic lookup_hit(input logic [63:0] pc, input logic [31:0] exp_instr);
        FE_PC  = pc;
        FE_REQ = 1'b1;
        push_instr(exp_instr, 1'b0);
        step();
        FE_REQ = 1'b0;
    endtask

    // words = {w3, w2, w1, w0}; err/flush beat -1 means none
    task automatic miss_refill(input logic [63:0] pc, input logic [127:0] words,
                               input int err_beat, input int flush_beat, input int stall);
        logic [63:0] line;
        line   = {pc[63:4], 4'h0};
        FE_PC  = pc;
        FE_REQ = 1'b1;
        @(negedge CLK);
        check("miss_no_hit", {63'h0, ICACHE_R}, 64'h0);
        step();
        FE_REQ = 1'b0;
        FE_PC  = pc ^ 64'h0000_0000_0000_7770;
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            check("stall_req", {63'h0, MEM_REQ}, 64'h1);
            check("stall_addr", MEM_ADDR, line);
            check("stall_r", {63'h0, ICACHE_R}, 64'h0);
            step();
        end
        for (int b = 0; b < 4; b++) begin
            push_addr(line + 64'(4 * b));
            MEM_RDY  = 1'b1;
            MEM_DATA = words[b*32 +: 32];
            MEM_ERR  = (b == err_beat);
            FLUSH    = (b == flush_beat);
            if (b == err_beat) push_instr(32'h0, 1'b1);
            step();
            MEM_RDY = 1'b0;
            MEM_ERR = 1'b0;
            FLUSH   = 1'b0;
            if (b == err_beat) begin
                step();
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; FE_PC = 64'h0; FE_REQ = 1'b0; FLUSH = 1'b0;
        MEM_RDY = 1'b0; MEM_DATA = 32'h0; MEM_ERR = 1'b0;
        step(); step();
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_r", {63'h0, ICACHE_R}, 64'h0);
        check("rst_iaf", {63'h0, ICACHE_IAF}, 64'h0);
        check("rst_mem_req", {63'h0, MEM_REQ}, 64'h0);
        check("rst_mem_addr", MEM_ADDR, 64'h0);
        check("rst_instr", {32'h0, ICACHE_INSTR}, 64'h0);
        step();

        // cold miss then same-line and conflicting lookups
        miss_refill(64'h1008, 128'h00000044_00000033_00000022_00000011, -1, -1, 0);
        lookup_hit(64'h1008, 32'h33);
        lookup_hit(64'h100C, 32'h44);
        lookup_hit(64'h1001, 32'h11);
        miss_refill(64'h1404, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, -1, -1, 0);
        lookup_hit(64'h1404, 32'hA2A2A2A2);
        miss_refill(64'h1008, 128'h00000044_00000033_00000022_00000011, -1, -1, 0);
        lookup_hit(64'h1000, 32'h11);

        // error on beat 2, then retry from beat 0
        miss_refill(64'h2010, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001, 2, -1, 0);
        miss_refill(64'h2010, 128'hBEEF0004_BEEF0003_BEEF0002_BEEF0001, -1, -1, 0);
        lookup_hit(64'h2018, 32'hBEEF0003);

        // flush during refill (beat 1 and on the final beat)
        miss_refill(64'h3020, 128'h30000004_30000003_30000002_30000001, -1, 1, 0);
        miss_refill(64'h3020, 128'h31000004_31000003_31000002_31000001, -1, 3, 0);
        miss_refill(64'h3020, 128'h32000004_32000003_32000002_32000001, -1, -1, 0);
        lookup_hit(64'h302C, 32'h32000004);

        // flush and lookup in the same IDLE cycle: no hit, no miss
        FE_PC = 64'h3024; FE_REQ = 1'b1; FLUSH = 1'b1;
        @(negedge CLK);
        check("flush_lookup_r", {63'h0, ICACHE_R}, 64'h0);
        step();
        FE_REQ = 1'b0; FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_no_miss", {63'h0, MEM_REQ}, 64'h0);
        step();
        miss_refill(64'h3024, 128'h33000004_33000003_33000002_33000001, -1, -1, 0);
        lookup_hit(64'h3024, 32'h33000002);

        // stalled memory on beat 0
        miss_refill(64'h4000, 128'h40000004_40000003_40000002_40000001, -1, -1, 5);
        lookup_hit(64'h4008, 32'h40000003);

        // reset arriving with beat 2
        FE_PC = 64'h5004; FE_REQ = 1'b1;
        step();
        FE_REQ = 1'b0;
        for (int b = 0; b < 2; b++) begin
            push_addr(64'h5000 + 64'(4 * b));
            MEM_RDY = 1'b1; MEM_DATA = 32'h50000001 + b;
            step();
        end
        MEM_RDY = 1'b1; MEM_DATA = 32'h50000003; RESET = 1'b1;
        @(negedge CLK);
        check("rst_cycle_req", {63'h0, MEM_REQ}, 64'h0);
        step();
        RESET = 1'b0; MEM_RDY = 1'b0;
        @(negedge CLK);
        check("post_rst_req", {63'h0, MEM_REQ}, 64'h0);
        check("post_rst_addr", MEM_ADDR, 64'h0);
        step();
        miss_refill(64'h5004, 128'h51000004_51000003_51000002_51000001, -1, -1, 0);
        lookup_hit(64'h5004, 32'h51000002);

        step(); step();
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
